hs_bus_amba_axis_reg_slice: RTL and testbench



---
 rtl/hs_bus_amba_axis_pkg.sv | 27 ++
 rtl/hs_bus_amba_axis_if.sv | 52 +++++
 rtl/hs_bus_amba_axis_beat_reg.sv | 21 ++
 rtl/hs_bus_amba_axis_reg_slice.sv | 124 ++++++++++++
 tb/tb_hs_bus_amba_axis_reg_slice.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/hs_bus_amba_axis_pkg.sv
// Shared types and constants for the AXI-Stream register slice.
package hs_bus_amba_axis_pkg;

    // Slice occupancy state. Each code equals the number of beats held.
    typedef enum logic [1:0] {
        AXIS_EMPTY = 2'd0,
        AXIS_ONE   = 2'd1,
        AXIS_FULL  = 2'd2
    } axis_slice_state_e;

    // Maximum number of beats the slice can hold (main + skid).
    localparam int AXIS_SLICE_DEPTH = 2;

    // Width of the flattened payload: every field except tvalid/tready.
    // The two extra bits are tlast and twakeup.
    function automatic int axis_payload_width(
        input int data_w,
        input int strb_w,
        input int keep_w,
        input int id_w,
        input int dest_w,
        input int user_w
    );
        return data_w + strb_w + keep_w + id_w + dest_w + user_w + 2;
    endfunction

endpackage

// File: rtl/hs_bus_amba_axis_if.sv
// AXI-Stream interface bundle with built-in handshake protocol assertions.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both 1. Once tvalid is raised it must stay high, with every payload field
// stable, until that transfer happens; tready may change freely.
interface hs_bus_amba_axis_if #(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8
) (
    input logic aclk,
    input logic aresetn
);

    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic [TSTRB_WIDTH-1:0] tstrb;
    logic [TKEEP_WIDTH-1:0] tkeep;
    logic                   tlast;
    logic [TID_WIDTH-1:0]   tid;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TUSER_WIDTH-1:0] tuser;
    logic                   twakeup;

    modport master (
        input  aclk, aresetn, tready,
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup
    );

    modport slave (
        input  aclk, aresetn, tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser, twakeup,
        output tready
    );

    // A stalled beat keeps tvalid asserted until it is accepted.
    a_hold_valid: assert property (
        @(posedge aclk) disable iff (!aresetn)
        (aresetn && tvalid && !tready) |=> tvalid
    );

    // A stalled beat keeps its whole payload stable until it is accepted.
    a_hold_payload: assert property (
        @(posedge aclk) disable iff (!aresetn)
        (aresetn && tvalid && !tready) |=>
            $stable({twakeup, tuser, tdest, tid, tlast, tkeep, tstrb, tdata})
    );

endinterface

// File: rtl/hs_bus_amba_axis_beat_reg.sv
// One flattened AXI-Stream beat held in a load-enabled register.
module hs_bus_amba_axis_beat_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Capture the beat on load; clear to zero on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/hs_bus_amba_axis_reg_slice.sv
// Full-throughput AXI-Stream register slice (skid buffer). Both the forward
// path (tvalid + payload) and the backward path (tready) come straight from
// flops, adding one cycle of latency while sustaining one beat per cycle.
module hs_bus_amba_axis_reg_slice
    import hs_bus_amba_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = 8,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1,
    parameter int TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter int TSTRB_WIDTH = TDATA_WIDTH / 8
) (
    input  logic                      aclk,
    input  logic                      areset,
    hs_bus_amba_axis_if.slave         s_axis,
    hs_bus_amba_axis_if.master        m_axis,
    output logic [1:0]                level
);

    localparam int PW = axis_payload_width(TDATA_WIDTH, TSTRB_WIDTH, TKEEP_WIDTH,
                                           TID_WIDTH, TDEST_WIDTH, TUSER_WIDTH);

    axis_slice_state_e state_q;
    axis_slice_state_e state_d;

    logic          vld_q;
    logic          rdy_q;
    logic          in_hs;
    logic          out_hs;
    logic          main_load;
    logic          skid_load;
    logic          main_from_skid;
    logic [PW-1:0] in_beat;
    logic [PW-1:0] main_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] skid_q;

    // Flatten the upstream payload; the same field order is used to unpack main.
    assign in_beat = {s_axis.twakeup, s_axis.tuser, s_axis.tdest, s_axis.tid,
                      s_axis.tlast, s_axis.tkeep, s_axis.tstrb, s_axis.tdata};

    // rdy_q is preloaded to 1 during reset so tready rises in the very first
    // cycle after reset; the areset gate holds tready low while reset is held.
    assign s_axis.tready = rdy_q & ~areset;

    assign in_hs  = s_axis.tvalid & s_axis.tready;
    assign out_hs = vld_q & m_axis.tready;

    // Next-state and register-load decode for the main/skid pair.
    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        main_from_skid = 1'b0;
        unique case (state_q)
            AXIS_EMPTY: begin
                if (in_hs) begin
                    state_d   = AXIS_ONE;
                    main_load = 1'b1;
                end
            end
            AXIS_ONE: begin
                if (in_hs && out_hs) begin
                    main_load = 1'b1;
                end else if (in_hs) begin
                    state_d   = AXIS_FULL;
                    skid_load = 1'b1;
                end else if (out_hs) begin
                    state_d = AXIS_EMPTY;
                end
            end
            AXIS_FULL: begin
                if (out_hs) begin
                    state_d        = AXIS_ONE;
                    main_load      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: begin
                state_d = AXIS_EMPTY;
            end
        endcase
    end

    // State plus registered tvalid/tready, both derived from the next state.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= AXIS_EMPTY;
            vld_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            vld_q   <= (state_d != AXIS_EMPTY);
            rdy_q   <= (state_d != AXIS_FULL);
        end
    end

    // Main loads either the live input beat or the beat parked in skid.
    assign main_d = main_from_skid ? skid_q : in_beat;

    hs_bus_amba_axis_beat_reg #(.WIDTH(PW)) u_main (
        .clk  (aclk),
        .rst  (areset),
        .load (main_load),
        .d    (main_d),
        .q    (main_q)
    );

    hs_bus_amba_axis_beat_reg #(.WIDTH(PW)) u_skid (
        .clk  (aclk),
        .rst  (areset),
        .load (skid_load),
        .d    (in_beat),
        .q    (skid_q)
    );

    assign m_axis.tvalid = vld_q;
    assign {m_axis.twakeup, m_axis.tuser, m_axis.tdest, m_axis.tid,
            m_axis.tlast, m_axis.tkeep, m_axis.tstrb, m_axis.tdata} = main_q;

    assign level = state_q;

endmodule

// File: tb/tb_hs_bus_amba_axis_reg_slice.sv
// Bench for the AXI-Stream register slice. The reference model is a plain
// FIFO of accepted-but-not-delivered beats: its size is the expected level.
module tb_hs_bus_amba_axis_reg_slice;

    localparam int DW  = 16;
    localparam int IW  = 2;
    localparam int DEW = 3;
    localparam int UW  = 4;
    localparam int KW  = DW / 8;
    localparam int SW  = DW / 8;
    localparam int PW  = DW + SW + KW + IW + DEW + UW + 2;

    logic       aclk = 1'b0;
    logic       areset = 1'b1;
    logic [1:0] level;

    always #5 aclk = ~aclk;

    hs_bus_amba_axis_if #(
        .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DEW),
        .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW), .TSTRB_WIDTH(SW)
    ) s_if (.aclk(aclk), .aresetn(~areset));

    hs_bus_amba_axis_if #(
        .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DEW),
        .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW), .TSTRB_WIDTH(SW)
    ) m_if (.aclk(aclk), .aresetn(~areset));

    hs_bus_amba_axis_reg_slice #(
        .TDATA_WIDTH(DW), .TID_WIDTH(IW), .TDEST_WIDTH(DEW),
        .TUSER_WIDTH(UW), .TKEEP_WIDTH(KW), .TSTRB_WIDTH(SW)
    ) dut (
        .aclk   (aclk),
        .areset (areset),
        .s_axis (s_if),
        .m_axis (m_if),
        .level  (level)
    );

    int            checks = 0;
    int            passes = 0;
    int            out_cnt = 0;
    bit            s_busy = 1'b0;
    logic [PW-1:0] cur_beat;
    logic [PW-1:0] exp_q[$];
    logic [PW-1:0] src_q[$];
    logic [PW-1:0] got_q[$];
    logic [PW-1:0] held;

    // Watchdog: the whole run is a few thousand cycles.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, checks=%0d passed=%0d", checks, passes);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [PW-1:0] mk_beat(input logic [DW-1:0] d, input logic last,
                                              input logic [IW-1:0] id, input logic [UW-1:0] user);
        return {1'b0, user, {DEW{1'b0}}, id, last, {KW{1'b0}}, {SW{1'b0}}, d};
    endfunction

    function automatic logic [PW-1:0] rand_beat();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] m_payload();
        return {m_if.twakeup, m_if.tuser, m_if.tdest, m_if.tid,
                m_if.tlast, m_if.tkeep, m_if.tstrb, m_if.tdata};
    endfunction

    task automatic drive_s(input logic vld, input logic [PW-1:0] b);
        s_if.tvalid = vld;
        {s_if.twakeup, s_if.tuser, s_if.tdest, s_if.tid,
         s_if.tlast, s_if.tkeep, s_if.tstrb, s_if.tdata} = b;
    endtask

    // Compare DUT outputs against the FIFO model.
    task automatic check_outputs();
        check("level", level, exp_q.size());
        check("m_tvalid", m_if.tvalid, exp_q.size() > 0);
        check("s_tready", s_if.tready, exp_q.size() < 2);
        if (exp_q.size() > 0) check("m_payload", m_payload(), exp_q[0]);
    endtask

    // One clock: drive at negedge, update model at posedge, check at next negedge.
    task automatic cycle(input int vpct, input bit rdy);
        bit in_hs;
        bit out_hs;
        if (!s_busy && src_q.size() > 0 && $urandom_range(99) < vpct) begin
            cur_beat = src_q.pop_front();
            s_busy = 1'b1;
        end
        if (s_busy) drive_s(1'b1, cur_beat);
        else drive_s(1'b0, rand_beat());
        m_if.tready = rdy;
        in_hs  = s_if.tvalid && s_if.tready;
        out_hs = m_if.tvalid && m_if.tready;
        if (out_hs) got_q.push_back(m_payload());
        @(posedge aclk);
        if (out_hs) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            out_cnt++;
        end
        if (in_hs) begin
            exp_q.push_back(cur_beat);
            s_busy = 1'b0;
        end
        @(negedge aclk);
        check_outputs();
    endtask

    initial begin
        drive_s(1'b0, '0);
        m_if.tready = 1'b1;

        // Reset for 3 cycles, then one beat through.
        areset = 1'b1;
        repeat (3) begin
            @(posedge aclk);
            @(negedge aclk);
            check("rst_s_tready", s_if.tready, 0);
            check("rst_m_tvalid", m_if.tvalid, 0);
            check("rst_level", level, 0);
            check("rst_payload", m_payload(), 0);
        end
        areset = 1'b0;
        #1;
        check("post_rst_s_tready", s_if.tready, 1);
        src_q.push_back(mk_beat(16'h00A5, 1'b1, 2'd1, 4'd1));
        cycle(100, 1'b1);
        check("single_level1", level, 1);
        check("single_tvalid", m_if.tvalid, 1);
        check("single_tdata", m_if.tdata, 16'h00A5);
        check("single_tlast", m_if.tlast, 1);
        cycle(100, 1'b1);
        check("single_level0", level, 0);
        check("single_out_cnt", out_cnt, 1);

        // Streaming 16 beats with tready held high.
        out_cnt = 0;
        got_q.delete();
        for (int i = 0; i < 16; i++)
            src_q.push_back(mk_beat(DW'(i), i == 15, IW'($urandom), UW'($urandom)));
        for (int k = 0; k < 17; k++) begin
            cycle(100, 1'b1);
            check("stream_no_bubble", out_cnt, k);
            if (k < 16) check("stream_level", level, 1);
        end
        check("stream_count", got_q.size(), 16);
        for (int i = 0; i < got_q.size(); i++) begin
            held = got_q[i];
            check("stream_tdata", held[DW-1:0], i);
        end

        // Stall for 4 cycles after beat 2 has been delivered.
        out_cnt = 0;
        got_q.delete();
        for (int i = 0; i < 8; i++)
            src_q.push_back(mk_beat(DW'(i), i == 7, IW'($urandom), UW'($urandom)));
        for (int k = 0; k < 20 && out_cnt < 3; k++) cycle(100, 1'b1);
        check("stall_prefix", out_cnt, 3);
        held = m_payload();
        for (int k = 0; k < 4; k++) begin
            cycle(100, 1'b0);
            check("stall_level", level, 2);
            check("stall_s_tready", s_if.tready, 0);
            check("stall_stable", m_payload(), held);
        end
        for (int k = 0; k < 30 && out_cnt < 8; k++) cycle(100, 1'b1);
        check("stall_count", got_q.size(), 8);
        for (int i = 0; i < got_q.size(); i++) begin
            held = got_q[i];
            check("stall_tdata", held[DW-1:0], i);
        end

        // Random valid/ready, 1000 fully random beats.
        out_cnt = 0;
        for (int i = 0; i < 1000; i++) src_q.push_back(rand_beat());
        for (int k = 0; k < 20000 && out_cnt < 1000; k++) cycle(50, 1'($urandom_range(1)));
        check("random_count", out_cnt, 1000);
        check("random_drained", exp_q.size() + src_q.size(), 0);

        // Reset while FULL.
        out_cnt = 0;
        for (int i = 0; i < 4; i++) src_q.push_back(rand_beat());
        cycle(100, 1'b0);
        cycle(100, 1'b0);
        check("pre_reset_full", level, 2);
        areset = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        check("mid_rst_m_tvalid", m_if.tvalid, 0);
        check("mid_rst_level", level, 0);
        exp_q.delete();
        src_q.delete();
        s_busy = 1'b0;
        drive_s(1'b0, '0);
        areset = 1'b0;
        #1;
        check("mid_rst_s_tready", s_if.tready, 1);
        for (int k = 0; k < 5; k++) cycle(0, 1'b1);
        check("no_stale", out_cnt, 0);
        for (int i = 0; i < 3; i++) src_q.push_back(rand_beat());
        for (int k = 0; k < 20 && out_cnt < 3; k++) cycle(100, 1'b1);
        check("post_rst_traffic", out_cnt, 3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
